// File: rtl/io_bridge_pkg.sv
// Shared types and default timing for the DE2-style board I/O bridge.
// Holds the LCD write FSM state encoding and helpers for sizing counters.
package io_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        GAP
    } lcd_state_e;

    localparam int DEF_DEB_CYCLES = 1000000;
    localparam int DEF_LCD_SETUP  = 2;
    localparam int DEF_LCD_PULSE  = 12;
    localparam int DEF_LCD_HOLD   = 2;
    localparam int DEF_LCD_GAP    = 2500;

    function automatic int maxOf4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // A down-counter holding len-1 needs $clog2(len) bits, but never fewer than one.
    function automatic int cntWidth(input int maxLen);
        return (maxLen > 1) ? $clog2(maxLen) : 1;
    endfunction

endpackage

// File: rtl/io_board_bridge_if.sv
// LCD request channel plus HD44780 pin bundle, as seen by a requester and by the bridge.
interface io_board_bridge_if;

    logic       lcdValid;
    logic       lcdReady;
    logic       lcdRs;
    logic [7:0] lcdData;
    logic       lcdOn;

    logic       pinEn;
    logic       pinRs;
    logic       pinRw;
    logic       pinOn;
    logic [7:0] pinData;

    modport master (
        output lcdValid, lcdRs, lcdData, lcdOn,
        input  lcdReady, pinEn, pinRs, pinRw, pinOn, pinData
    );

    modport slave (
        input  lcdValid, lcdRs, lcdData, lcdOn,
        output lcdReady, pinEn, pinRs, pinRw, pinOn, pinData
    );

endinterface

// File: rtl/sw_debounce.sv
// One switch bit: two-flop synchroniser followed by a run-length debounce counter.
module sw_debounce
    import io_bridge_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pad_i,
    output logic sw_o
);

    localparam int CW = cntWidth(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any disagreement must persist for DEB_CYCLES consecutive clocks before it is adopted.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= pad_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sw_o = stable_q;

endmodule

// File: rtl/io_board_bridge.sv
// Board I/O bridge: debounced switches in, registered LED/HEX mirrors out,
// and a timed HD44780 write sequencer driven by a valid/ready request channel.
module io_board_bridge
    import io_bridge_pkg::*;
#(
    parameter int SW_W       = 17,
    parameter int LEDR_W     = 17,
    parameter int LEDG_W     = 8,
    parameter int NUM_HEX    = 8,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int LCD_SETUP  = DEF_LCD_SETUP,
    parameter int LCD_PULSE  = DEF_LCD_PULSE,
    parameter int LCD_HOLD   = DEF_LCD_HOLD,
    parameter int LCD_GAP    = DEF_LCD_GAP
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [SW_W-1:0]      sw_pad_i,
    output logic [31:0]          io_sw_o,
    input  logic [31:0]          io_ledr_i,
    input  logic [31:0]          io_ledg_i,
    input  logic [NUM_HEX*7-1:0] io_hex_i,
    output logic [LEDR_W-1:0]    ledr_o,
    output logic [LEDG_W-1:0]    ledg_o,
    output logic [NUM_HEX*7-1:0] hex_o,
    input  logic                 lcd_valid_i,
    output logic                 lcd_ready_o,
    input  logic                 lcd_rs_i,
    input  logic [7:0]           lcd_data_i,
    input  logic                 lcd_on_i,
    output logic                 lcd_en_o,
    output logic                 lcd_rs_o,
    output logic                 lcd_rw_o,
    output logic                 lcd_on_o,
    output logic [7:0]           lcd_data_o
);

    localparam int MAX_PH = maxOf4(LCD_SETUP, LCD_PULSE, LCD_HOLD, LCD_GAP);
    localparam int PH_W   = cntWidth(MAX_PH);

    lcd_state_e        state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              rs_q;
    logic [7:0]        data_q;
    logic              lcdOn_q;
    logic [LEDR_W-1:0] ledr_q;
    logic [LEDG_W-1:0] ledg_q;
    logic [NUM_HEX*7-1:0] hex_q;
    logic              accept;
    logic              unusedLedBits;

    assign unusedLedBits = ^{io_ledr_i, io_ledg_i};

    // Bits above SW_W are tied low so the CPU always sees a 32-bit word.
    for (genvar i = 0; i < 32; i++) begin : g_sw
        if (i < SW_W) begin : g_bit
            sw_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk_i (clk_i),
                .rst_ni(rst_ni),
                .pad_i (sw_pad_i[i]),
                .sw_o  (io_sw_o[i])
            );
        end else begin : g_zero
            assign io_sw_o[i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ledr_q  <= '0;
            ledg_q  <= '0;
            hex_q   <= '1;
            lcdOn_q <= 1'b0;
        end else begin
            ledr_q  <= io_ledr_i[LEDR_W-1:0];
            ledg_q  <= io_ledg_i[LEDG_W-1:0];
            hex_q   <= io_hex_i;
            lcdOn_q <= lcd_on_i;
        end
    end

    // Each phase counts down from len-1; the counter reloads whenever the state changes.
    function automatic logic [PH_W-1:0] phaseLoad(input lcd_state_e s);
        case (s)
            SETUP:   return PH_W'(LCD_SETUP - 1);
            PULSE:   return PH_W'(LCD_PULSE - 1);
            HOLD:    return PH_W'(LCD_HOLD - 1);
            GAP:     return PH_W'(LCD_GAP - 1);
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            IDLE:    if (lcd_valid_i) state_d = SETUP;
            SETUP:   if (phase_q == '0) state_d = PULSE;
            PULSE:   if (phase_q == '0) state_d = HOLD;
            HOLD:    if (phase_q == '0) state_d = GAP;
            GAP:     if (phase_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            phase_d = phaseLoad(state_d);
        end else if (phase_q != '0) begin
            phase_d = phase_q - 1'b1;
        end
    end

    // Enable decodes straight from state so an async reset drops it without waiting for a clock.
    always_comb begin
        lcd_ready_o = (state_q == IDLE);
        lcd_en_o    = (state_q == PULSE);
    end

    assign accept = lcd_valid_i && lcd_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rs_q   <= 1'b0;
            data_q <= '0;
        end else if (accept) begin
            rs_q   <= lcd_rs_i;
            data_q <= lcd_data_i;
        end
    end

    assign ledr_o     = ledr_q;
    assign ledg_o     = ledg_q;
    assign hex_o      = hex_q;
    assign lcd_on_o   = lcdOn_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = data_q;
    assign lcd_rw_o   = 1'b0;

endmodule

// File: tb/tb_io_board_bridge.sv
// Self-checking bench for io_board_bridge with short debounce and LCD timing;
// LCD writes go through a scoreboard queue popped on each enable pulse.
module tb_io_board_bridge;

    typedef struct {
        logic       rs;
        logic [7:0] data;
    } lcdReq_t;

    logic        clk;
    logic        rst_n;
    logic [16:0] swPad;
    logic [31:0] ioSw;
    logic [31:0] ioLedr;
    logic [31:0] ioLedg;
    logic [55:0] ioHex;
    logic [16:0] ledrOut;
    logic [7:0]  ledgOut;
    logic [55:0] hexOut;

    int checks   = 0;
    int failures = 0;

    lcdReq_t lcdExpQ[$];

    io_board_bridge_if lcdIf();

    io_board_bridge #(
        .SW_W      (17),
        .LEDR_W    (17),
        .LEDG_W    (8),
        .NUM_HEX   (8),
        .DEB_CYCLES(4),
        .LCD_SETUP (2),
        .LCD_PULSE (3),
        .LCD_HOLD  (1),
        .LCD_GAP   (5)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .sw_pad_i   (swPad),
        .io_sw_o    (ioSw),
        .io_ledr_i  (ioLedr),
        .io_ledg_i  (ioLedg),
        .io_hex_i   (ioHex),
        .ledr_o     (ledrOut),
        .ledg_o     (ledgOut),
        .hex_o      (hexOut),
        .lcd_valid_i(lcdIf.lcdValid),
        .lcd_ready_o(lcdIf.lcdReady),
        .lcd_rs_i   (lcdIf.lcdRs),
        .lcd_data_i (lcdIf.lcdData),
        .lcd_on_i   (lcdIf.lcdOn),
        .lcd_en_o   (lcdIf.pinEn),
        .lcd_rs_o   (lcdIf.pinRs),
        .lcd_rw_o   (lcdIf.pinRw),
        .lcd_on_o   (lcdIf.pinOn),
        .lcd_data_o (lcdIf.pinData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise a write request, queue its expected pin values, and return on the clock after acceptance.
    task automatic applyStimulus(input logic rs, input logic [7:0] data);
        bit accepted;
        lcdReq_t req;
        accepted          = 1'b0;
        req.rs            = rs;
        req.data          = data;
        lcdExpQ.push_back(req);
        lcdIf.lcdValid    = 1'b1;
        lcdIf.lcdRs       = rs;
        lcdIf.lcdData     = data;
        for (int n = 0; n < 50; n++) begin
            if (lcdIf.lcdReady) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) checkOutput("lcdAcceptTimeout", 64'd0, 64'd1);
        @(negedge clk);
        lcdIf.lcdValid = 1'b0;
    endtask

    // Every enable pulse is one completed write: pop its expectation and time the pulse width.
    logic    enPrev = 1'b0;
    int      enLen  = 0;
    lcdReq_t expReq;
    always @(negedge clk) begin
        if (!rst_n) begin
            enPrev = 1'b0;
            enLen  = 0;
        end else begin
            if (lcdIf.pinEn && !enPrev) begin
                if (lcdExpQ.size() == 0) begin
                    checkOutput("sbUnexpectedWrite", 64'd1, 64'd0);
                end else begin
                    expReq = lcdExpQ.pop_front();
                    checkOutput("sbRs", 64'(lcdIf.pinRs), 64'(expReq.rs));
                    checkOutput("sbData", 64'(lcdIf.pinData), 64'(expReq.data));
                end
                enLen = 1;
            end else if (lcdIf.pinEn) begin
                enLen++;
            end else if (enPrev) begin
                checkOutput("enWidth", 64'(enLen), 64'd3);
            end
            enPrev = lcdIf.pinEn;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        swPad          = '0;
        ioLedr         = '0;
        ioLedg         = '0;
        ioHex          = '0;
        lcdIf.lcdValid = 1'b0;
        lcdIf.lcdRs    = 1'b0;
        lcdIf.lcdData  = '0;
        lcdIf.lcdOn    = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rstSw", 64'(ioSw), 64'd0);
        checkOutput("rstHex", 64'(hexOut), {8'h00, 56'hFF_FFFF_FFFF_FFFF});
        checkOutput("rstLedr", 64'(ledrOut), 64'd0);
        checkOutput("rstEn", 64'(lcdIf.pinEn), 64'd0);
        checkOutput("rstData", 64'(lcdIf.pinData), 64'd0);
        checkOutput("rstRw", 64'(lcdIf.pinRw), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postRstReady", 64'(lcdIf.lcdReady), 64'd1);
        checkOutput("postRstSw", 64'(ioSw), 64'd0);

        ioLedr      = 32'hFFFF_1234;
        ioLedg      = 32'hABCD_EF5A;
        ioHex       = 56'h01_2345_6789_ABCD;
        lcdIf.lcdOn = 1'b1;
        #1;
        checkOutput("ledrLatency", 64'(ledrOut), 64'd0);
        @(negedge clk);
        checkOutput("ledrMirror", 64'(ledrOut), 64'h1_1234);
        checkOutput("ledgMirror", 64'(ledgOut), 64'h5A);
        checkOutput("hexMirror", 64'(hexOut), 64'h01_2345_6789_ABCD);
        checkOutput("lcdOnMirror", 64'(lcdIf.pinOn), 64'd1);

        swPad[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checkOutput("sw0Edge", 64'(ioSw), (k == 6) ? 64'h1 : 64'h0);
        end
        swPad[5] = 1'b1;
        repeat (3) @(negedge clk);
        swPad[5] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("sw5Glitch", 64'(ioSw), 64'h1);
        end
        swPad[16] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checkOutput("sw16Edge", 64'(ioSw), (k == 6) ? 64'h1_0001 : 64'h1);
        end
        swPad = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checkOutput("swRelease", 64'(ioSw), (k == 6) ? 64'h0 : 64'h1_0001);
        end

        applyStimulus(1'b1, 8'h41);
        for (int i = 1; i <= 12; i++) begin
            if (i > 1) @(negedge clk);
            checkOutput("lcdEn", 64'(lcdIf.pinEn), (i >= 3 && i <= 5) ? 64'd1 : 64'd0);
            checkOutput("lcdReady", 64'(lcdIf.lcdReady), (i == 12) ? 64'd1 : 64'd0);
            checkOutput("lcdData", 64'(lcdIf.pinData), 64'h41);
            checkOutput("lcdRs", 64'(lcdIf.pinRs), 64'd1);
        end

        applyStimulus(1'b0, 8'h38);
        lcdIf.lcdValid = 1'b1;
        lcdIf.lcdRs    = 1'b1;
        lcdIf.lcdData  = 8'h55;
        lcdExpQ.push_back('{rs: 1'b1, data: 8'h55});
        for (int i = 1; i <= 13; i++) begin
            if (i > 1) @(negedge clk);
            checkOutput("b2bData", 64'(lcdIf.pinData), (i <= 12) ? 64'h38 : 64'h55);
            checkOutput("b2bReady", 64'(lcdIf.lcdReady), (i == 12) ? 64'd1 : 64'd0);
        end
        lcdIf.lcdValid = 1'b0;
        repeat (11) @(negedge clk);
        checkOutput("b2bDone", 64'(lcdIf.lcdReady), 64'd1);

        applyStimulus(1'b1, 8'hC3);
        repeat (2) @(negedge clk);
        checkOutput("preRstEn", 64'(lcdIf.pinEn), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstEn", 64'(lcdIf.pinEn), 64'd0);
        checkOutput("midRstReady", 64'(lcdIf.lcdReady), 64'd1);
        checkOutput("midRstData", 64'(lcdIf.pinData), 64'd0);
        checkOutput("midRstOn", 64'(lcdIf.pinOn), 64'd0);
        checkOutput("midRstHex", 64'(hexOut), {8'h00, 56'hFF_FFFF_FFFF_FFFF});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("relReady", 64'(lcdIf.lcdReady), 64'd1);
        checkOutput("relEn", 64'(lcdIf.pinEn), 64'd0);

        applyStimulus(1'b0, 8'h01);
        repeat (11) @(negedge clk);
        checkOutput("finalReady", 64'(lcdIf.lcdReady), 64'd1);
        checkOutput("sbEmpty", 64'(lcdExpQ.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
